angle_atan2: RTL and testbench



---
 rtl/angle_atan2.sv | 201 ++++++++++++++++++++
 tb/tb_angle_atan2.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/angle_atan2.sv
// angle_atan2: recovers the electrical angle (0.1 degree units, 0..3599) from a
// sign-magnitude sin/cos pair. It uses an iterative CORDIC in vectoring mode on
// the first-quadrant magnitudes, then unfolds the quadrant from the sign bits.
// Optional feature macro: ANGLE_ATAN2_MAG_EN adds the registered output
// mag_out, the gain-corrected vector magnitude.
module angle_atan2 #(
   parameter int ITER = 12
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [11:0] sin_val,
   input  logic        sin_sign,
   input  logic [11:0] cos_val,
   input  logic        cos_sign,
   output logic        busy,
   output logic        done,
   output logic [11:0] angle_out
`ifdef ANGLE_ATAN2_MAG_EN
   ,
   output logic [12:0] mag_out
`endif
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_FIX  = 2'd2;

   localparam logic [3:0] LAST_ITER = 4'(ITER - 1);

   logic [1:0]         state_q, state_d;
   logic [3:0]         i_q, i_d;
   logic signed [15:0] x_q, x_d;
   logic signed [15:0] y_q, y_d;
   logic signed [15:0] z_q, z_d;
   logic               neg_sin_q, neg_sin_d;
   logic               neg_cos_q, neg_cos_d;
   logic               zero_q, zero_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [11:0]        angle_q, angle_d;
`ifdef ANGLE_ATAN2_MAG_EN
   logic [12:0]        mag_q, mag_d;
   logic [31:0]        x_ext;
`endif

   logic signed [15:0] atan_step;
   logic signed [15:0] z_rnd;
   logic [11:0]        a_val;
   logic [11:0]        unfolded;
   logic [11:0]        angle_fix;

   // Arctangent table: atan(2^-i) in degrees scaled by 160 (0.1 deg, 4 fraction bits).
   always_comb begin
      atan_step = 16'sd0;
      case (i_q)
         4'd0:    atan_step = 16'sd7200;
         4'd1:    atan_step = 16'sd4250;
         4'd2:    atan_step = 16'sd2246;
         4'd3:    atan_step = 16'sd1140;
         4'd4:    atan_step = 16'sd572;
         4'd5:    atan_step = 16'sd286;
         4'd6:    atan_step = 16'sd143;
         4'd7:    atan_step = 16'sd72;
         4'd8:    atan_step = 16'sd36;
         4'd9:    atan_step = 16'sd18;
         4'd10:   atan_step = 16'sd9;
         4'd11:   atan_step = 16'sd4;
         default: atan_step = 16'sd0;
      endcase
   end

   // Round the accumulated angle to 0.1 deg, clamp to the first quadrant, then unfold.
   always_comb begin
      z_rnd = (z_q + 16'sd8) >>> 4;
      a_val = 12'd0;
      if (z_rnd < 16'sd0) begin
         a_val = 12'd0;
      end else if (z_rnd > 16'sd900) begin
         a_val = 12'd900;
      end else begin
         a_val = z_rnd[11:0];
      end
      unfolded = a_val;
      case ({neg_sin_q, neg_cos_q})
         2'b00:   unfolded = a_val;
         2'b01:   unfolded = 12'd1800 - a_val;
         2'b11:   unfolded = 12'd1800 + a_val;
         default: unfolded = 12'd3600 - a_val;
      endcase
      angle_fix = unfolded;
      if (zero_q || (unfolded == 12'd3600)) begin
         angle_fix = 12'd0;
      end
   end

   // Next-state logic: load in IDLE, rotate towards y=0 in RUN, publish in FIX.
   always_comb begin
      state_d   = state_q;
      i_d       = i_q;
      x_d       = x_q;
      y_d       = y_q;
      z_d       = z_q;
      neg_sin_d = neg_sin_q;
      neg_cos_d = neg_cos_q;
      zero_d    = zero_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      angle_d   = angle_q;
`ifdef ANGLE_ATAN2_MAG_EN
      mag_d     = mag_q;
      x_ext     = {16'd0, x_q};
`endif
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               neg_sin_d = sin_sign && (sin_val != 12'd0);
               neg_cos_d = cos_sign && (cos_val != 12'd0);
               zero_d    = (sin_val == 12'd0) && (cos_val == 12'd0);
               x_d       = $signed({4'd0, cos_val});
               y_d       = $signed({4'd0, sin_val});
               z_d       = 16'sd0;
               i_d       = 4'd0;
               busy_d    = 1'b1;
               state_d   = ST_RUN;
            end
         end
         ST_RUN: begin
            if (!y_q[15]) begin
               x_d = x_q + (y_q >>> i_q);
               y_d = y_q - (x_q >>> i_q);
               z_d = z_q + atan_step;
            end else begin
               x_d = x_q - (y_q >>> i_q);
               y_d = y_q + (x_q >>> i_q);
               z_d = z_q - atan_step;
            end
            i_d = i_q + 4'd1;
            if (i_q == LAST_ITER) begin
               state_d = ST_FIX;
            end
         end
         ST_FIX: begin
            angle_d = angle_fix;
`ifdef ANGLE_ATAN2_MAG_EN
            mag_d   = 13'((x_ext * 32'd19899 + 32'd16384) >> 15);
`endif
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any conversion without a done pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         i_q       <= 4'd0;
         x_q       <= 16'sd0;
         y_q       <= 16'sd0;
         z_q       <= 16'sd0;
         neg_sin_q <= 1'b0;
         neg_cos_q <= 1'b0;
         zero_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         angle_q   <= 12'd0;
`ifdef ANGLE_ATAN2_MAG_EN
         mag_q     <= 13'd0;
`endif
      end else begin
         state_q   <= state_d;
         i_q       <= i_d;
         x_q       <= x_d;
         y_q       <= y_d;
         z_q       <= z_d;
         neg_sin_q <= neg_sin_d;
         neg_cos_q <= neg_cos_d;
         zero_q    <= zero_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         angle_q   <= angle_d;
`ifdef ANGLE_ATAN2_MAG_EN
         mag_q     <= mag_d;
`endif
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign angle_out = angle_q;
`ifdef ANGLE_ATAN2_MAG_EN
   assign mag_out   = mag_q;
`endif

endmodule

// File: tb/tb_angle_atan2.sv
// Testbench for angle_atan2: directed vectors with hand-computed angles pushed
// into a scoreboard; a monitor pops and compares on every done pulse, including
// the expected completion cycle. Define ANGLE_ATAN2_MAG_EN to also check mag_out.
module tb_angle_atan2;

   logic        clk;
   logic        rst;
   logic        start;
   logic [11:0] sin_val;
   logic        sin_sign;
   logic [11:0] cos_val;
   logic        cos_sign;
   logic        busy;
   logic        done;
   logic [11:0] angle_out;
`ifdef ANGLE_ATAN2_MAG_EN
   logic [12:0] mag_out;
`endif

   typedef struct {
      string name;
      int    angle;
      int    tol;
      int    mag;
      int    due;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   angle_atan2 #(.ITER(12)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .sin_val   (sin_val),
      .sin_sign  (sin_sign),
      .cos_val   (cos_val),
      .cos_sign  (cos_sign),
      .busy      (busy),
      .done      (done),
      .angle_out (angle_out)
`ifdef ANGLE_ATAN2_MAG_EN
      ,
      .mag_out   (mag_out)
`endif
   );

   // Free-running clock, 10 ns period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Count rising edges so completion latency can be checked.
   always @(posedge clk) begin
      cyc <= cyc + 1;
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Drive one request at the current (post-negedge) time; optionally record its expectation.
   task automatic applyStimulus(input string name, input logic [11:0] s, input logic ss,
                                input logic [11:0] c, input logic cs, input int exp_angle,
                                input int tol, input int exp_mag, input bit push);
      exp_t e;
      sin_val  = s;
      sin_sign = ss;
      cos_val  = c;
      cos_sign = cs;
      start    = 1'b1;
      if (push) begin
         e.name  = name;
         e.angle = exp_angle;
         e.tol   = tol;
         e.mag   = exp_mag;
         e.due   = cyc + 1 + 13;
         sb.push_back(e);
      end
      @(negedge clk);
      start    = 1'b0;
      sin_val  = 12'($urandom_range(0, 4095));
      sin_sign = 1'($urandom_range(0, 1));
      cos_val  = 12'($urandom_range(0, 4095));
      cos_sign = 1'($urandom_range(0, 1));
   endtask

   // Wait (bounded) for the scoreboard to drain.
   task automatic waitEmpty(input string name, input int budget);
      int n;
      n = 0;
      while (sb.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL %s_timeout: got %0d pending results, expected 0", name, sb.size());
         sb.delete();
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      exp_t e;
      int   diff;
      if (!rst && done) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_done: got done with angle %0d, expected no done", angle_out);
         end else begin
            e = sb.pop_front();
            diff = int'(angle_out) - e.angle;
            if (diff < 0) diff = -diff;
            checks++;
            if (diff > e.tol) begin
               errors++;
               $display("[TB] FAIL %s_angle: got %0d, expected %0d +/- %0d", e.name, angle_out, e.angle, e.tol);
            end
            checkOutput({e.name, "_latency"}, cyc, e.due);
`ifdef ANGLE_ATAN2_MAG_EN
            diff = int'(mag_out) - e.mag;
            if (diff < 0) diff = -diff;
            checks++;
            if (diff > 2) begin
               errors++;
               $display("[TB] FAIL %s_mag: got %0d, expected %0d +/- 2", e.name, mag_out, e.mag);
            end
`endif
         end
      end
   end

   // Directed test sequence.
   initial begin
      int n;
      rst      = 1'b1;
      start    = 1'b0;
      sin_val  = 12'd0;
      sin_sign = 1'b0;
      cos_val  = 12'd0;
      cos_sign = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_done", done, 0);
      checkOutput("reset_angle", angle_out, 0);
`ifdef ANGLE_ATAN2_MAG_EN
      checkOutput("reset_mag", mag_out, 0);
`endif
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Pure cos axis, with busy profile over the whole conversion.
      applyStimulus("cos_axis", 12'd0, 1'b0, 12'd4000, 1'b0, 0, 0, 4000, 1'b1);
      for (int k = 0; k < 13; k++) begin
         checkOutput("busy_run", busy, 1);
         @(negedge clk);
      end
      checkOutput("busy_after", busy, 0);
      waitEmpty("cos_axis", 40);

      applyStimulus("q1_45", 12'd2000, 1'b0, 12'd2000, 1'b0, 450, 1, 2828, 1'b1);
      waitEmpty("q1_45", 40);
      applyStimulus("q2_120", 12'd3464, 1'b0, 12'd2000, 1'b1, 1200, 1, 4000, 1'b1);
      waitEmpty("q2_120", 40);
      applyStimulus("q3_225", 12'd1000, 1'b1, 12'd1000, 1'b1, 2250, 1, 1414, 1'b1);
      waitEmpty("q3_225", 40);
      applyStimulus("q4_3586", 12'd100, 1'b1, 12'd4095, 1'b0, 3586, 1, 4096, 1'b1);
      waitEmpty("q4_3586", 40);
      applyStimulus("wrap_0", 12'd1, 1'b1, 12'd4095, 1'b0, 0, 0, 4095, 1'b1);
      waitEmpty("wrap_0", 40);
      applyStimulus("sin_axis_neg", 12'd4095, 1'b1, 12'd0, 1'b0, 2700, 0, 4095, 1'b1);
      waitEmpty("sin_axis_neg", 40);
      applyStimulus("zero_vec", 12'd0, 1'b1, 12'd0, 1'b1, 0, 0, 0, 1'b1);
      waitEmpty("zero_vec", 40);

      // Re-pulse of start mid-run must be ignored.
      applyStimulus("repulse", 12'd2000, 1'b0, 12'd2000, 1'b0, 450, 1, 2828, 1'b1);
      repeat (3) @(negedge clk);
      applyStimulus("ignored", 12'd4095, 1'b1, 12'd0, 1'b0, 2700, 0, 4095, 1'b0);
      waitEmpty("repulse", 40);
      repeat (20) @(negedge clk);

      // Reset mid-conversion aborts immediately with no done.
      applyStimulus("aborted", 12'd1000, 1'b1, 12'd1000, 1'b1, 2250, 1, 1414, 1'b0);
      repeat (6) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      checkOutput("abort_busy", busy, 0);
      checkOutput("abort_done", done, 0);
      checkOutput("abort_angle", angle_out, 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);

      // Fresh conversion after reset, then a back-to-back start in the done cycle.
      applyStimulus("post_reset", 12'd3464, 1'b0, 12'd2000, 1'b1, 1200, 1, 4000, 1'b1);
      n = 0;
      while (!done && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("[TB] FAIL b2b_wait: got no done, expected done within 40 cycles");
      end
      applyStimulus("back_to_back", 12'd1000, 1'b1, 12'd1000, 1'b1, 2250, 1, 1414, 1'b1);
      waitEmpty("back_to_back", 40);
      repeat (5) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
